// File: rtl/demux_serial_rx.sv
// Serial frame receiver: one sample per clk_2 edge, LSB-first data demuxed into a word.
// Optional even-parity check is built when PARITY_CHECK_EN is defined.
module demux_serial_rx #(
  parameter int NBITS = 8
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic             ser_in,
  output logic [NBITS-1:0] data_out,
  output logic             valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [NBITS-1:0] shreg;
  logic             start_frame;
  logic             stop_ok;
  logic             stop_bad;

`ifdef PARITY_CHECK_EN
  logic par_bad;
`endif

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ser_in) begin
          state_d     = DATA;
          start_frame = 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: state_d = STOP;
`endif
      STOP: begin
        if (ser_in) begin
          state_d = IDLE;
`ifdef PARITY_CHECK_EN
          stop_ok = !par_bad;
`else
          stop_ok = 1'b1;
`endif
        end else begin
          state_d  = WAIT_IDLE;
          stop_bad = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (ser_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Datapath: bit demux, word capture on a clean stop bit, sticky error flags
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= stop_ok;
      if (start_frame)
        bit_cnt <= '0;
      else if (state_q == DATA && bit_cnt != LAST_BIT)
        bit_cnt <= bit_cnt + CNT_W'(1);
      if (state_q == DATA)
        shreg[bit_cnt] <= ser_in;
      if (stop_ok) begin
        data_out  <= shreg;
        frame_err <= 1'b0;
      end
      if (stop_bad)
        frame_err <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  // Even parity over data plus parity bit; par_bad holds this frame's verdict until STOP
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_frame)
        par_bad <= 1'b0;
      if (state_q == PARITY && ((^shreg) ^ ser_in)) begin
        par_bad    <= 1'b1;
        parity_err <= 1'b1;
      end
      if (stop_ok)
        parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/demux_serial_rx.md
DEMUX_SERIAL_RX -- requirements
Module: demux_serial_rx

Interface
REQ-001 Parameter NBITS, default 8: number of data bits per frame and width of data_out.
REQ-002 clk_2  input  1: single clock, all state updates on rising edge.
REQ-003 rst_n  input  1: reset, asynchronous, active-low.
REQ-004 ser_in  input  1: serial line; idle high; LSB-first frames produced by the companion 2:1 mux serializer.
REQ-005 data_out  output  NBITS: last correctly received word; each received bit is demultiplexed to position bit_cnt.
REQ-006 valid  output  1: one-cycle pulse marking a new data_out.
REQ-007 frame_err  output  1: sticky flag, stop bit sampled low.
REQ-008 parity_err  output  1: sticky flag, parity mismatch; exists in every build.
REQ-009 busy  output  1: high whenever the receiver is not in IDLE.

Function
REQ-010 The line shall be sampled once per clk_2 rising edge; one sample equals one bit; no oversampling.
REQ-011 The FSM shall have states IDLE, DATA, PARITY (macro builds only), STOP, WAIT_IDLE.
REQ-012 IDLE: on ser_in=0, go to DATA with bit_cnt=0; on ser_in=1, stay in IDLE.
REQ-013 DATA: write ser_in into shift register bit bit_cnt, then increment bit_cnt; after bit NBITS-1, go to PARITY if enabled, else STOP.
REQ-014 bit_cnt shall be $clog2(NBITS) bits wide and shall never wrap within a frame; it is cleared on entry to DATA.
REQ-015 STOP with ser_in=1 and no pending parity error:
- data_out loads the shift register on that edge.
- valid is high for exactly the following cycle.
- frame_err and parity_err clear.
- Next state is IDLE.
REQ-016 STOP with ser_in=0:
- frame_err sets.
- data_out holds.
- valid stays low.
- Next state is WAIT_IDLE.
REQ-017 WAIT_IDLE shall return to IDLE only after sampling ser_in=1, so a stuck-low line never produces a frame.
REQ-018 Back-to-back frames: a start bit sampled in the cycle immediately after STOP (IDLE) shall be accepted, giving minimum frame spacing of NBITS+2 cycles (NBITS+3 with parity).
REQ-019 Latency: valid rises one cycle after the edge sampling the stop bit; data_out is stable from that cycle until the next accepted frame.
REQ-020 busy shall be low in IDLE and high in DATA, PARITY, STOP and WAIT_IDLE.

Reset
REQ-021 While rst_n=0, regardless of clk_2, outputs shall be:
- state=IDLE, bit_cnt=0, shift register=0.
- data_out=0.
- valid=0, frame_err=0, parity_err=0, busy=0.
REQ-022 Reset mid-frame shall discard the partial word; the first frame after rst_n rises shall be received normally.

Configuration
REQ-023 Macro PARITY_CHECK_EN defined:
- PARITY state samples one bit after the data bits.
- Even parity is required over data+parity bit.
- Mismatch sets parity_err, suppresses valid and leaves data_out unchanged at STOP.
- The stop bit is still checked.
REQ-024 Macro PARITY_CHECK_EN undefined:
- No PARITY state exists; DATA goes directly to STOP.
- parity_err is tied to 0.

Verification
REQ-025 Reset, then ser_in idle high for 20 cycles -> busy=0, valid never pulses, data_out=0x00.
REQ-026 Frame 0,1,0,1,0,0,1,0,1,1 (start, data LSB first = 0xA5, stop), no parity -> data_out=0xA5, single valid pulse one cycle after stop sample.
REQ-027 Two frames 0x3C then 0xFF with zero idle gap -> two valid pulses 10 cycles apart; data_out=0x3C then 0xFF.
REQ-028 Frame 0x5A with stop bit 0, line held low 5 cycles, then high -> frame_err=1, data_out unchanged, busy until first high sample; next good frame 0x01 clears frame_err.
REQ-029 rst_n pulsed low after the 4th data bit of a 0xC3 frame -> all outputs 0 immediately; following frame 0x81 received correctly.
REQ-030 PARITY_CHECK_EN build: 0x07 with parity bit 1 -> valid, data_out=0x07; same word with parity bit 0 -> parity_err=1, no valid.
